light_sequencer: RTL and testbench

//  Traffic-light phase FSM; consumer of the time-parameter stage. Drives interval[1:0] to select a duration,

---
 rtl/light_sequencer_pkg.sv | 68 ++++++
 rtl/light_sequencer_phase_countdown.sv | 91 +++++++++
 rtl/light_sequencer.sv | 139 +++++++++++++
 tb/tb_light_sequencer.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/light_sequencer_pkg.sv
// light_sequencer_pkg: state, phase, interval and lamp codes plus output decode.
// Build option: LS_WALK_EN adds the pedestrian S_WALK state.
package light_sequencer_pkg;

  localparam logic [2:0] S_MG1  = 3'd0;
  localparam logic [2:0] S_MG2  = 3'd1;
  localparam logic [2:0] S_MY   = 3'd2;
  localparam logic [2:0] S_SG   = 3'd3;
  localparam logic [2:0] S_SY   = 3'd4;
  localparam logic [2:0] S_WALK = 3'd5;

  localparam logic [1:0] P_SET  = 2'd0;
  localparam logic [1:0] P_WAIT = 2'd1;
  localparam logic [1:0] P_RUN  = 2'd2;

  localparam logic [1:0] IV_TB  = 2'b00;
  localparam logic [1:0] IV_TE  = 2'b01;
  localparam logic [1:0] IV_TY  = 2'b10;
  localparam logic [1:0] IV_2TB = 2'b11;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  typedef struct packed {
    logic [1:0] iv;
    logic [2:0] main;
    logic [2:0] side;
  } ls_out_t;

  localparam ls_out_t LS_OUT_RST = '{
    iv:   IV_TB,
    main: LAMP_G,
    side: LAMP_R
  };

  // Interval and lamp pattern belonging to a state.
  function automatic ls_out_t ls_decode(
    input logic [2:0] st
  );
    ls_out_t o;
    o = LS_OUT_RST;
    case (st)
      S_MG1: o = '{iv: IV_TB, main: LAMP_G, side: LAMP_R};
      S_MG2: o = '{iv: IV_TE, main: LAMP_G, side: LAMP_R};
      S_MY:  o = '{iv: IV_TY, main: LAMP_Y, side: LAMP_R};
      S_SG:  o = '{iv: IV_TB, main: LAMP_R, side: LAMP_G};
      S_SY:  o = '{iv: IV_TY, main: LAMP_R, side: LAMP_Y};
`ifdef LS_WALK_EN
      S_WALK: o = '{iv: IV_2TB, main: LAMP_R, side: LAMP_R};
`endif
      default: o = LS_OUT_RST;
    endcase
    return o;
  endfunction

  // Encodings outside the built state set are illegal.
  function automatic logic ls_legal(
    input logic [2:0] st
  );
`ifdef LS_WALK_EN
    return st <= S_WALK;
`else
    return st <= S_SY;
`endif
  endfunction

endpackage

// File: rtl/light_sequencer_phase_countdown.sv
// light_sequencer_phase_countdown: settle wait, duration capture, tick countdown.
// done_o pulses on the tick that ends the phase; the counter rearms itself.
module light_sequencer_phase_countdown
  import light_sequencer_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] value_i,
  output logic             done_o
);

  localparam int SW =
    (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LAST =
    SW'(SETTLE_CYC - 2);

  logic [1:0]       phase_q, phase_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic             done;

  // Phase sequencing: set -> settle -> capture -> countdown.
  always_comb begin
    phase_d  = phase_q;
    count_d  = count_q;
    settle_d = settle_q;
    done     = 1'b0;
    if (clr_i) begin
      phase_d  = P_SET;
      count_d  = '0;
      settle_d = '0;
    end else begin
      unique case (1'b1)
        (phase_q == P_SET): begin
          phase_d  = P_WAIT;
          settle_d = '0;
        end
        (phase_q == P_WAIT): begin
          if (settle_q == SETTLE_LAST) begin
            phase_d = P_RUN;
            // A zero duration still lasts one tick.
            if (value_i == '0) begin
              count_d = CNT_W'(1);
            end else begin
              count_d = value_i;
            end
          end else begin
            settle_d = settle_q + SW'(1);
          end
        end
        (phase_q == P_RUN): begin
          if (tick_i) begin
            if (count_q <= CNT_W'(1)) begin
              done    = 1'b1;
              phase_d = P_SET;
              count_d = '0;
            end else begin
              count_d = count_q - CNT_W'(1);
            end
          end
        end
        default: begin
          phase_d  = P_SET;
          count_d  = '0;
          settle_d = '0;
        end
      endcase
    end
  end

  // Phase, settle and countdown registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= P_SET;
      count_q  <= '0;
      settle_q <= '0;
    end else begin
      phase_q  <= phase_d;
      count_q  <= count_d;
      settle_q <= settle_d;
    end
  end

  assign done_o = done;

endmodule

// File: rtl/light_sequencer.sv
// light_sequencer: traffic-light phase FSM with registered lamp/interval outputs.
// Build option: LS_WALK_EN enables the walk request latch and S_WALK phase.
module light_sequencer
  import light_sequencer_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter int SETTLE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1hz,
  input  logic             prog_sync,
  input  logic             sensor,
  input  logic             walk_req,
  input  logic [CNT_W-1:0] value,
  output logic [1:0]       interval,
  output logic [2:0]       main_lights,
  output logic [2:0]       side_lights,
  output logic             walk_lamp
);

  logic [2:0] state_q, state_d;
  logic       sens_q, sens_d;
  ls_out_t    out_q, out_d;
  logic       legal;
  logic       clr;
  logic       done;

`ifdef LS_WALK_EN
  logic walk_q, walk_d;
  logic wlamp_q, wlamp_d;
`endif

  // Restart or bad encoding pulls everything back to S_MG1/P_SET.
  assign legal = ls_legal(state_q);
  assign clr   = prog_sync | ~legal;

  light_sequencer_phase_countdown #(
    .CNT_W      (CNT_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .tick_i  (tick_1hz),
    .value_i (value),
    .done_o  (done)
  );

  // Next state, request latches and the outputs of the next state.
  always_comb begin
    state_d = state_q;
    sens_d  = sens_q;
`ifdef LS_WALK_EN
    walk_d  = walk_q;
`endif
    if (clr) begin
      state_d = S_MG1;
      sens_d  = 1'b0;
`ifdef LS_WALK_EN
      walk_d  = 1'b0;
`endif
    end else begin
      if (state_q == S_MG1 && sensor) begin
        sens_d = 1'b1;
      end
`ifdef LS_WALK_EN
      if (state_q != S_WALK && walk_req) begin
        walk_d = 1'b1;
      end
`endif
      if (done) begin
        case (state_q)
          S_MG1:  state_d = sens_q ? S_MG2 : S_MY;
          S_MG2:  state_d = S_MY;
`ifdef LS_WALK_EN
          S_MY:   state_d = walk_q ? S_WALK : S_SG;
          S_WALK: state_d = S_SG;
`else
          S_MY:   state_d = S_SG;
`endif
          S_SG:   state_d = S_SY;
          S_SY:   state_d = S_MG1;
          default: state_d = S_MG1;
        endcase
        // Sensor only extends the green it was seen in.
        if (state_q == S_MG1) begin
          sens_d = 1'b0;
        end
`ifdef LS_WALK_EN
        if (state_d == S_WALK) begin
          walk_d = 1'b0;
        end
`endif
      end
    end
    out_d = ls_decode(state_d);
`ifdef LS_WALK_EN
    wlamp_d = (state_d == S_WALK);
`endif
  end

  // State, sensor latch and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_MG1;
      sens_q  <= 1'b0;
      out_q   <= LS_OUT_RST;
    end else begin
      state_q <= state_d;
      sens_q  <= sens_d;
      out_q   <= out_d;
    end
  end

`ifdef LS_WALK_EN
  // Walk request latch and walk lamp register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      walk_q  <= 1'b0;
      wlamp_q <= 1'b0;
    end else begin
      walk_q  <= walk_d;
      wlamp_q <= wlamp_d;
    end
  end

  assign walk_lamp = wlamp_q;
`else
  logic unused_walk_req;
  assign unused_walk_req = walk_req;
  assign walk_lamp       = 1'b0;
`endif

  assign interval    = out_q.iv;
  assign main_lights = out_q.main;
  assign side_lights = out_q.side;

endmodule

// File: tb/tb_light_sequencer.sv
// tb_light_sequencer: scoreboard bench for the traffic-light sequencer.
// Expected phases are queued per scenario and checked as the lamps change.
module tb_light_sequencer;

  localparam int ST_MG1  = 0;
  localparam int ST_MG2  = 1;
  localparam int ST_MY   = 2;
  localparam int ST_SG   = 3;
  localparam int ST_SY   = 4;
  localparam int ST_WALK = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_1hz;
  logic       prog_sync;
  logic       sensor;
  logic       walk_req;
  logic [3:0] value;
  logic [1:0] interval;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk_lamp;

  int checks = 0;
  int errors = 0;
  int tb_v = 6;
  int te_v = 3;
  int ty_v = 2;
  bit tick_en = 1'b0;
  int tdiv = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [8:0] o;
    int         ticks;
    string      name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  light_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_1hz    (tick_1hz),
    .prog_sync   (prog_sync),
    .sensor      (sensor),
    .walk_req    (walk_req),
    .value       (value),
    .interval    (interval),
    .main_lights (main_lights),
    .side_lights (side_lights),
    .walk_lamp   (walk_lamp)
  );

  // Registered time-parameter stage upstream of the sequencer.
  always @(posedge clk) begin
    case (interval)
      2'b00:   value <= 4'(tb_v);
      2'b01:   value <= 4'(te_v);
      2'b10:   value <= 4'(ty_v);
      default: value <= 4'(2 * tb_v);
    endcase
  end

  // One-cycle tick every 10 clocks, phase set by tdiv.
  initial begin
    tick_1hz = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (tick_en) begin
        tick_1hz = (tdiv == 9);
        tdiv = (tdiv == 9) ? 0 : tdiv + 1;
      end else begin
        tick_1hz = 1'b0;
      end
    end
  end

  function automatic logic [8:0] exp_of(input int st);
    case (st)
      ST_MG1:  return {2'b00, 3'b001, 3'b100, 1'b0};
      ST_MG2:  return {2'b01, 3'b001, 3'b100, 1'b0};
      ST_MY:   return {2'b10, 3'b010, 3'b100, 1'b0};
      ST_SG:   return {2'b00, 3'b100, 3'b001, 1'b0};
      ST_SY:   return {2'b10, 3'b100, 3'b010, 1'b0};
      ST_WALK: return {2'b11, 3'b100, 3'b100, 1'b1};
      default: return 9'h0;
    endcase
  endfunction

  task automatic push(input int st, input int t, input string nm);
    exp_t e;
    e.o = exp_of(st);
    e.ticks = t;
    e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: a state ends when outputs change; check it and its tick count.
  logic [8:0] cur, prev;
  int         nt = 0;
  logic       tk;
  always @(posedge clk) begin
    exp_t e;
    tk = tick_1hz;
    #1;
    cur = {interval, main_lights, side_lights, walk_lamp};
    if (!mon_en) begin
      prev = cur;
      nt = 0;
    end else begin
      if (tk === 1'b1) nt++;
      if (cur !== prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change from %b to %b", prev, cur);
        end else begin
          e = sb.pop_front();
          checks++;
          if (prev !== e.o) begin
            errors++;
            $display("FAIL %s_outputs got %b want %b", e.name, prev, e.o);
          end
          if (e.ticks >= 0) begin
            checks++;
            if (nt != e.ticks) begin
              errors++;
              $display("FAIL %s_ticks got %0d want %0d", e.name, nt, e.ticks);
            end
          end
        end
        prev = cur;
        nt = 0;
      end
    end
  end

  task automatic release_reset(input int t0);
    rst_n = 1'b1;
    tdiv = t0;
    tick_en = 1'b1;
  endtask

  task automatic do_reset(input int t0);
    @(negedge clk);
    mon_en = 1'b0;
    tick_en = 1'b0;
    rst_n = 1'b0;
    sensor = 1'b0;
    walk_req = 1'b0;
    prog_sync = 1'b0;
    repeat (3) @(negedge clk);
    sb.delete();
    release_reset(t0);
    mon_en = 1'b1;
  endtask

  task automatic wait_drain(input int budget, output bit ok);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    ok = (sb.size() == 0);
    if (!ok) sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (interval !== 2'b00) begin
      errors++;
      $display("FAIL reset_interval got %b want 00", interval);
    end
    checks++;
    if (main_lights !== 3'b001) begin
      errors++;
      $display("FAIL reset_main got %b want 001", main_lights);
    end
    checks++;
    if (side_lights !== 3'b100) begin
      errors++;
      $display("FAIL reset_side got %b want 100", side_lights);
    end
    checks++;
    if (walk_lamp !== 1'b0) begin
      errors++;
      $display("FAIL reset_walk got %b want 0", walk_lamp);
    end
    release_reset(0);
    mon_en = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if ({interval, main_lights, side_lights, walk_lamp} !== exp_of(ST_MG1)) begin
      errors++;
      $display("FAIL reset_hold got %b want %b",
               {interval, main_lights, side_lights, walk_lamp}, exp_of(ST_MG1));
    end
  endtask

  task automatic test_normal_cycle();
    bit ok;
    do_reset(0);
    push(ST_MG1, 6, "norm_mg1");
    push(ST_MY, 2, "norm_my");
    push(ST_SG, 6, "norm_sg");
    push(ST_SY, 2, "norm_sy");
    wait_drain(400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL norm_drain got timeout want drained");
    end
    checks++;
    if ({interval, main_lights, side_lights, walk_lamp} !== exp_of(ST_MG1)) begin
      errors++;
      $display("FAIL norm_wrap got %b want %b",
               {interval, main_lights, side_lights, walk_lamp}, exp_of(ST_MG1));
    end
  endtask

  task automatic test_sensor();
    bit ok;
    bit seen;
    do_reset(0);
    push(ST_MG1, 6, "sens_mg1");
    push(ST_MG2, 3, "sens_mg2");
    push(ST_MY, 2, "sens_my");
    push(ST_SG, 6, "sens_sg");
    push(ST_SY, 2, "sens_sy");
    push(ST_MG1, 6, "sens_mg1b");
    push(ST_MY, 2, "sens_myb");
    repeat (25) @(negedge clk);
    sensor = 1'b1;
    @(negedge clk);
    sensor = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = (side_lights === 3'b001);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL sens_reach_sg got timeout want side 001");
    end
    sensor = 1'b1;
    @(negedge clk);
    sensor = 1'b0;
    wait_drain(600, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sens_drain got timeout want drained");
    end
  endtask

  task automatic test_prog_sync();
    bit ok;
    bit seen;
    int n;
    do_reset(0);
    push(ST_MG1, 6, "ps_mg1");
    push(ST_MY, 2, "ps_my");
    push(ST_SG, 2, "ps_sg_cut");
    push(ST_MG1, 6, "ps_mg1_full");
    push(ST_MY, 2, "ps_my2");
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = (side_lights === 3'b001);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ps_reach_sg got timeout want side 001");
    end
    n = 0;
    for (int i = 0; i < 100 && n < 2; i++) begin
      @(posedge clk);
      if (tick_1hz === 1'b1) n++;
    end
    @(negedge clk);
    prog_sync = 1'b1;
    @(negedge clk);
    prog_sync = 1'b0;
    checks++;
    if ({interval, main_lights, side_lights, walk_lamp} !== exp_of(ST_MG1)) begin
      errors++;
      $display("FAIL ps_immediate got %b want %b",
               {interval, main_lights, side_lights, walk_lamp}, exp_of(ST_MG1));
    end
    wait_drain(400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ps_drain got timeout want drained");
    end
    @(negedge clk);
    mon_en = 1'b0;
    prog_sync = 1'b1;
    repeat (80) @(negedge clk);
    checks++;
    if ({interval, main_lights, side_lights, walk_lamp} !== exp_of(ST_MG1)) begin
      errors++;
      $display("FAIL ps_frozen got %b want %b",
               {interval, main_lights, side_lights, walk_lamp}, exp_of(ST_MG1));
    end
    prog_sync = 1'b0;
  endtask

  task automatic test_zero_tb();
    bit ok;
    tb_v = 0;
    do_reset(9);
    push(ST_MG1, 2, "z_mg1");
    push(ST_MY, 2, "z_my");
    push(ST_SG, 1, "z_sg");
    push(ST_SY, 2, "z_sy");
    wait_drain(300, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL z_drain got timeout want drained");
    end
    tb_v = 6;
  endtask

  task automatic test_walk();
    bit ok;
    do_reset(0);
    push(ST_MG1, 6, "w_mg1");
    push(ST_MY, 2, "w_my");
`ifdef LS_WALK_EN
    push(ST_WALK, 12, "w_walk");
    push(ST_SG, 6, "w_sg");
    push(ST_SY, 2, "w_sy");
    push(ST_MG1, 6, "w_mg1b");
    push(ST_MY, 2, "w_myb");
`else
    push(ST_SG, 6, "w_sg");
    push(ST_SY, 2, "w_sy");
`endif
    repeat (25) @(negedge clk);
    walk_req = 1'b1;
    @(negedge clk);
    walk_req = 1'b0;
    wait_drain(800, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL w_drain got timeout want drained");
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    bit seen;
    do_reset(0);
    push(ST_MG1, 6, "ar_mg1");
    push(ST_MY, 0, "ar_my_cut");
    push(ST_MG1, 6, "ar_mg1_full");
    push(ST_MY, 2, "ar_my2");
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = (main_lights === 3'b010);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ar_reach_my got timeout want main 010");
    end
    repeat (3) @(negedge clk);
    tick_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({interval, main_lights, side_lights, walk_lamp} !== exp_of(ST_MG1)) begin
      errors++;
      $display("FAIL ar_immediate got %b want %b",
               {interval, main_lights, side_lights, walk_lamp}, exp_of(ST_MG1));
    end
    @(negedge clk);
    release_reset(0);
    wait_drain(400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ar_drain got timeout want drained");
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    prog_sync = 1'b0;
    sensor = 1'b0;
    walk_req = 1'b0;
    test_reset();
    test_normal_cycle();
    test_sensor();
    test_prog_sync();
    test_zero_tb();
    test_walk();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
